set_assoc_cache: RTL
====================

// Module: set_assoc_cache
// PURPOSE
//   N-way set-associative, write-back, write-allocate data cache; next generation of the direct-mapped cache.
//   Sits between the pipeline memory stage (word request/satisfied handshake) and line-wide main memory.
//   Adds configurable associativity, invalid-first + per-set round-robin replacement, saturating hit/miss counters.
// PARAMETERS
//   REGISTER_SIZE    32   word width (bits)
//   REGS_PER_LINE    4    words per line (power of 2)
//   LINE_LENGTH      REGISTER_SIZE*REGS_PER_LINE  line width (derived)
//   SET_INDEX_SIZE   2    log2(number of sets)
//   WAYS             2    ways per set (power of 2, >=1)
//   ADDRESS_SIZE     32   word-address width
//   COUNTER_SIZE     16   width of hit/miss counters
// PORTS
//   clk            in   1                 clock, all state updates on rising edge
//   reset          in   1                 asynchronous, active-low reset
//   address        in   ADDRESS_SIZE      word address: {tag, set, offset}; offset = low log2(REGS_PER_LINE) bits
//   data           in   REGISTER_SIZE     store data
//   write          in   1                 1 = store, 0 = load
//   request        in   1                 access valid
//   result         out  REGISTER_SIZE     load data (valid when satisfied)
//   satisfied      out  1                 access completes this cycle
//   mem_req        out  1                 memory transaction active
//   mem_address    out  ADDRESS_SIZE      line-aligned address (offset bits 0)
//   mem_data       out  LINE_LENGTH       victim line for write-back, word j at bits [(j+1)*REGISTER_SIZE-1:j*REGISTER_SIZE]
//   mem_write      out  1                 1 = write-back, 0 = fill
//   mem_result     in   LINE_LENGTH       fill line, same packing as mem_data
//   mem_satisfied  in   1                 memory completes current transaction this cycle
//   hit_count      out  COUNTER_SIZE      saturating hit count
//   miss_count     out  COUNTER_SIZE      saturating miss count
// BEHAVIOUR
//   Reset (reset=0, async): state NORMAL; all valid/dirty/tags/lines/rr pointers/counters 0; satisfied=0, mem_req=0,
//     mem_write=0, result=0, counters=0. Reset mid-EVICT/FILL abandons the transaction; dirty data is lost.
//   Hit = some way in set has valid && tag==req_tag. satisfied = state==NORMAL && request && hit (combinational, 0-cycle).
//   Load hit: result = hit way's word[offset], same cycle. Store hit: word[offset]<=data, dirty<=1 at edge.
//   FSM NORMAL/EVICT/FILL:
//     NORMAL, request && !hit: latch victim way; victim valid&&dirty -> EVICT else -> FILL; miss_count+1.
//     Victim: lowest-index invalid way; if none, way = rr[set]; rr[set] advances (mod WAYS) only when used.
//     EVICT: mem_req=1, mem_write=1, mem_address={victim tag,set,0}, mem_data=victim line; mem_satisfied -> FILL.
//     FILL: mem_req=1, mem_write=0, mem_address={req_tag,set,0}; on mem_satisfied victim line<=mem_result,
//       tag<=req_tag, valid<=1, dirty<=0 -> NORMAL. Access then hits in NORMAL (miss latency = memory + 1 cycle).
//   mem_satisfied ignored in NORMAL. mem_req stays high until mem_satisfied (no abort).
//   Requester holds address/data/write/request stable until satisfied. Request dropped mid-miss: line still fills.
//   hit_count +1 per cycle with satisfied && !refilled; refilled set on FILL->NORMAL, cleared at next satisfied
//     or when request=0 (the post-fill completion is not a hit). Both counters saturate at all-ones.
//   WAYS=1 degenerates to direct-mapped; rr unused.
// TESTING  (defaults, COUNTER_SIZE=16 unless noted; set=addr[3:2])
//   1 Reset, load 0x10 -> mem_req=1, mem_write=0, mem_address=0x10; mem_result={W3..W0} + mem_satisfied -> next cycle satisfied=1, result=W0; miss_count=1, hit_count=0.
//   2 Load 0x11 after 1 -> satisfied same cycle, result=W1, no mem_req; hit_count=1.
//   3 Store 0x12 data 0xDEADBEEF -> satisfied same cycle; load 0x12 -> result=0xDEADBEEF.
//   4 Load 0x20 (fills way1), then load 0x30 -> EVICT mem_address=0x10, mem_data word2=0xDEADBEEF; then FILL mem_address=0x30; miss_count=3.
//   5 Assert reset during FILL -> mem_req=0, satisfied=0, counters 0 immediately; load 0x10 afterwards misses.
//   6 COUNTER_SIZE=2: one miss then 5 hit cycles on same line -> hit_count=3 (saturated), miss_count=1.

Source files
------------

// File: rtl/set_assoc_cache.sv
// Write-back, write-allocate, N-way set-associative data cache between a word-wide
// requester and line-wide main memory, with invalid-first/round-robin replacement.
//
// state  | meaning
// -------+------------------------------------------------------------
// NORMAL | lookup; hits complete combinationally, a miss picks a victim
// EVICT  | writing the dirty victim line back to memory
// FILL   | fetching the requested line into the victim way
module set_assoc_cache #(
    parameter int REGISTER_SIZE  = 32,
    parameter int REGS_PER_LINE  = 4,
    parameter int LINE_LENGTH    = REGISTER_SIZE * REGS_PER_LINE,
    parameter int SET_INDEX_SIZE = 2,
    parameter int WAYS           = 2,
    parameter int ADDRESS_SIZE   = 32,
    parameter int COUNTER_SIZE   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_SIZE-1:0]  address,
    input  logic [REGISTER_SIZE-1:0] data,
    input  logic                     write,
    input  logic                     request,
    output logic [REGISTER_SIZE-1:0] result,
    output logic                     satisfied,
    output logic                     mem_req,
    output logic [ADDRESS_SIZE-1:0]  mem_address,
    output logic [LINE_LENGTH-1:0]   mem_data,
    output logic                     mem_write,
    input  logic [LINE_LENGTH-1:0]   mem_result,
    input  logic                     mem_satisfied,
    output logic [COUNTER_SIZE-1:0]  hit_count,
    output logic [COUNTER_SIZE-1:0]  miss_count
);
    localparam int OFF_W = $clog2(REGS_PER_LINE);
    localparam int SETS  = 1 << SET_INDEX_SIZE;
    localparam int TAG_W = ADDRESS_SIZE - SET_INDEX_SIZE - OFF_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {NORMAL, EVICT, FILL} state_t;

    state_t                    state;
    logic                      valid [SETS][WAYS];
    logic                      dirty [SETS][WAYS];
    logic [TAG_W-1:0]          tags  [SETS][WAYS];
    logic [LINE_LENGTH-1:0]    lines [SETS][WAYS];
    logic [WAY_W-1:0]          rr    [SETS];

    logic [WAY_W-1:0]          victim;
    logic [TAG_W-1:0]          miss_tag;
    logic [SET_INDEX_SIZE-1:0] miss_set;
    logic                      refilled;

    logic [TAG_W-1:0]          req_tag;
    logic [SET_INDEX_SIZE-1:0] req_set;
    logic [OFF_W-1:0]          req_off;
    logic                      hit;
    logic [WAY_W-1:0]          hit_way;
    logic [WAY_W-1:0]          victim_way;
    logic                      use_rr;
    logic [WAY_W-1:0]          rr_next;

    assign req_tag = address[ADDRESS_SIZE-1 -: TAG_W];
    assign req_set = address[OFF_W +: SET_INDEX_SIZE];
    assign req_off = address[OFF_W-1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid[req_set][w] && tags[req_set][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Scanning downward leaves the lowest-index invalid way selected.
    always_comb begin
        victim_way = rr[req_set];
        use_rr     = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[req_set][w]) begin
                victim_way = WAY_W'(w);
                use_rr     = 1'b0;
            end
        end
    end

    assign rr_next = (rr[req_set] == WAY_W'(WAYS - 1)) ? '0 : rr[req_set] + 1'b1;

    assign satisfied = (state == NORMAL) && request && hit;
    assign result    = satisfied ? lines[req_set][hit_way][req_off*REGISTER_SIZE +: REGISTER_SIZE]
                                 : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= NORMAL;
            victim      <= '0;
            miss_tag    <= '0;
            miss_set    <= '0;
            refilled    <= 1'b0;
            mem_req     <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                    tags[s][w]  <= '0;
                    lines[s][w] <= '0;
                end
            end
        end else begin
            case (state)
                NORMAL: begin
                    if (request && hit) begin
                        if (write) begin
                            lines[req_set][hit_way][req_off*REGISTER_SIZE +: REGISTER_SIZE] <= data;
                            dirty[req_set][hit_way] <= 1'b1;
                        end
                        // The completion right after a fill is the tail of a miss.
                        if (!refilled && hit_count != {COUNTER_SIZE{1'b1}})
                            hit_count <= hit_count + 1'b1;
                        refilled <= 1'b0;
                    end else if (request) begin
                        victim   <= victim_way;
                        miss_tag <= req_tag;
                        miss_set <= req_set;
                        if (use_rr)
                            rr[req_set] <= rr_next;
                        if (miss_count != {COUNTER_SIZE{1'b1}})
                            miss_count <= miss_count + 1'b1;
                        mem_req <= 1'b1;
                        if (valid[req_set][victim_way] && dirty[req_set][victim_way]) begin
                            state       <= EVICT;
                            mem_write   <= 1'b1;
                            mem_address <= {tags[req_set][victim_way], req_set, {OFF_W{1'b0}}};
                            mem_data    <= lines[req_set][victim_way];
                        end else begin
                            state       <= FILL;
                            mem_write   <= 1'b0;
                            mem_address <= {req_tag, req_set, {OFF_W{1'b0}}};
                        end
                    end else begin
                        refilled <= 1'b0;
                    end
                end
                EVICT: begin
                    if (mem_satisfied) begin
                        state       <= FILL;
                        mem_write   <= 1'b0;
                        mem_address <= {miss_tag, miss_set, {OFF_W{1'b0}}};
                    end
                end
                FILL: begin
                    if (mem_satisfied) begin
                        lines[miss_set][victim] <= mem_result;
                        tags[miss_set][victim]  <= miss_tag;
                        valid[miss_set][victim] <= 1'b1;
                        dirty[miss_set][victim] <= 1'b0;
                        state                   <= NORMAL;
                        mem_req                 <= 1'b0;
                        refilled                <= 1'b1;
                    end
                end
                default: state <= NORMAL;
            endcase
        end
    end
endmodule
